// File: rtl/uart_comm_pkg.sv
// rtl/uart_comm_pkg.sv - shared types and constants for the UART packet host
// Contents: message types, packet length limits, response status codes,
// host state enumeration and the request byte generator.
package uart_comm_pkg;

    localparam logic [7:0] MSG_INFO    = 8'h00;
    localparam logic [7:0] MSG_INVALID = 8'h01;
    localparam logic [7:0] MSG_MIN_LEN = 8'd8;
    localparam logic [7:0] REQ_LEN     = 8'd8;

    localparam logic [2:0] RSP_OK      = 3'd0;
    localparam logic [2:0] RSP_TIMEOUT = 3'd1;
    localparam logic [2:0] RSP_BAD_LEN = 3'd2;
    localparam logic [2:0] RSP_BAD_HDR = 3'd3;
    localparam logic [2:0] RSP_RX_ERR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_LEN,
        ST_READ
    } state_e;

    // Request packets are fixed: length, two zero bytes, type, four zero pad bytes.
    function automatic logic [7:0] req_byte(input logic [2:0] idx, input logic [7:0] typ);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 3'd0) b = REQ_LEN;
        if (idx == 3'd3) b = typ;
        return b;
    endfunction

endpackage

// File: rtl/uart_comm_timer.sv
// rtl/uart_comm_timer.sv - inter-byte idle timeout counter
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   en             : count while the host waits for response bytes
//   load           : reload the full timeout (packet start or any received byte)
//   expire         : high while enabled and the count has run out
module uart_comm_timer #(
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Down-count from TIMEOUT_CYCLES-1 and hold at zero; the host leaves
    // its waiting states on expiry, so expire is effectively one cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == '0);

endmodule

// File: rtl/uart_comm_host.sv
// rtl/uart_comm_host.sv - host initiator for length-prefixed UART packets
// Ports:
//   sys_clk, rst_n          : clock (16x baud domain), asynchronous active-low reset
//   cmd_valid/cmd_type      : request strobe and message type; cmd_ready high in IDLE
//   tx_byte/transmit        : byte and one-cycle send pulse to the UART
//   is_transmitting         : UART transmitter busy
//   rx_byte/received        : byte and byte-valid pulse from the UART
//   recv_error              : UART framing error pulse
//   rsp_valid               : one-cycle completion pulse
//   rsp_status/type/length  : completion code, response byte 3, response byte 0
//   rsp_data                : payload bytes 4..11, byte 4 in [63:56]
module uart_comm_host
    import uart_comm_pkg::*;
#(
    parameter int MAX_LEN        = 60,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_type,
    output logic        cmd_ready,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        is_transmitting,
    input  logic [7:0]  rx_byte,
    input  logic        received,
    input  logic        recv_error,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic [7:0]  rsp_type,
    output logic [7:0]  rsp_length,
    output logic [63:0] rsp_data
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e      state_q, state_d;
    logic [7:0]  cmd_type_q, cmd_type_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d;
    logic        hdr_err_q, hdr_err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        transmit_q, transmit_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_status_q, rsp_status_d;
    logic [7:0]  rsp_type_q, rsp_type_d;
    logic [7:0]  rsp_length_q, rsp_length_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    logic        fin;
    logic [2:0]  fin_status;
    logic [2:0]  slot;
    logic        send_fire;
    logic        last_req;
    logic        timer_en;
    logic        timer_load;
    logic        timer_expire;

    // A pulse is never issued two cycles running: the UART only raises
    // is_transmitting one cycle after seeing transmit.
    assign send_fire  = !is_transmitting && !transmit_q;
    assign last_req   = (idx_q == (REQ_LEN - 8'd1));
    assign timer_en   = (state_q == ST_WAIT_LEN) || (state_q == ST_READ);
    assign timer_load = ((state_q == ST_SEND) && send_fire && last_req)
                      || (timer_en && received);

    // Payload byte 4 lands in the top byte lane, byte 11 in the bottom one.
    assign slot = 3'(8'd11 - idx_q);

    uart_comm_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .en     (timer_en),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        cmd_type_d   = cmd_type_q;
        idx_d        = idx_q;
        len_d        = len_q;
        hdr_err_d    = hdr_err_q;
        tx_byte_d    = tx_byte_q;
        transmit_d   = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_type_d   = rsp_type_q;
        rsp_length_d = rsp_length_q;
        rsp_data_d   = rsp_data_q;
        fin          = 1'b0;
        fin_status   = RSP_OK;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_type_d = cmd_type;
                    idx_d      = 8'd0;
                    rsp_data_d = 64'd0;
                    hdr_err_d  = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (send_fire) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = req_byte(idx_q[2:0], cmd_type_q);
                    idx_d      = idx_q + 8'd1;
                    if (last_req) begin
                        state_d = ST_WAIT_LEN;
                    end
                end
            end
            ST_WAIT_LEN: begin
                if (recv_error) begin
                    fin        = 1'b1;
                    fin_status = RSP_RX_ERR;
                end else if (received) begin
                    // A zero byte is line filler ahead of the length byte.
                    if (rx_byte != 8'h00) begin
                        rsp_length_d = rx_byte;
                        if ((rx_byte < MSG_MIN_LEN) || (rx_byte > MAX_LEN_B)) begin
                            fin        = 1'b1;
                            fin_status = RSP_BAD_LEN;
                        end else begin
                            len_d   = rx_byte;
                            idx_d   = 8'd1;
                            state_d = ST_READ;
                        end
                    end
                end else if (timer_expire) begin
                    fin        = 1'b1;
                    fin_status = RSP_TIMEOUT;
                end
            end
            ST_READ: begin
                if (recv_error) begin
                    fin        = 1'b1;
                    fin_status = RSP_RX_ERR;
                end else if (received) begin
                    idx_d = idx_q + 8'd1;
                    if (((idx_q == 8'd1) || (idx_q == 8'd2)) && (rx_byte != 8'h00)) begin
                        hdr_err_d = 1'b1;
                    end
                    if (idx_q == 8'd3) begin
                        rsp_type_d = rx_byte;
                    end
                    if ((idx_q >= 8'd4) && (idx_q <= 8'd11)) begin
                        rsp_data_d[{slot, 3'b000} +: 8] = rx_byte;
                    end
                    if (idx_q == (len_q - 8'd1)) begin
                        fin        = 1'b1;
                        fin_status = hdr_err_d ? RSP_BAD_HDR : RSP_OK;
                    end
                end else if (timer_expire) begin
                    fin        = 1'b1;
                    fin_status = RSP_TIMEOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = fin_status;
            state_d      = ST_IDLE;
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_type_q   <= 8'd0;
            idx_q        <= 8'd0;
            len_q        <= 8'd0;
            hdr_err_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
            tx_byte_q    <= 8'd0;
            transmit_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 3'd0;
            rsp_type_q   <= 8'd0;
            rsp_length_q <= 8'd0;
            rsp_data_q   <= 64'd0;
        end else begin
            state_q      <= state_d;
            cmd_type_q   <= cmd_type_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            hdr_err_q    <= hdr_err_d;
            cmd_ready_q  <= cmd_ready_d;
            tx_byte_q    <= tx_byte_d;
            transmit_q   <= transmit_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_type_q   <= rsp_type_d;
            rsp_length_q <= rsp_length_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign tx_byte    = tx_byte_q;
    assign transmit   = transmit_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_type   = rsp_type_q;
    assign rsp_length = rsp_length_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: doc/uart_comm_host.md
# uart_comm_host

Host-side initiator for the length-prefixed UART packet protocol. It frames single-byte-type request packets (INFO, PING, …) onto a byte-level UART, then collects and checks the response packet. It returns the response type, its length and the first 8 payload bytes on a one-cycle response strobe. It sits beside a `uart` instance (byte interface) and serves FPGA-to-FPGA links and loopback self-test of the miner's command link.

## Interface
- `MAX_LEN`, 60: largest accepted response length in bytes.
- `TIMEOUT_CYCLES`, 12000000: idle-line cycles allowed between response bytes (1 s at 12 MHz).
- `sys_clk  in  1`: single clock, 16x baud domain.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `cmd_valid  in  1`: request strobe.
- `cmd_type  in  8`: message type to send.
- `cmd_ready  out  1`: high only in IDLE.
- `tx_byte  out  8`: byte to the UART.
- `transmit  out  1`: one-cycle send pulse.
- `is_transmitting  in  1`: UART busy.
- `rx_byte  in  8`: byte from the UART.
- `received  in  1`: byte-valid pulse.
- `recv_error  in  1`: framing error pulse.
- `rsp_valid  out  1`: one-cycle completion pulse.
- `rsp_status  out  3`: 0 OK, 1 TIMEOUT, 2 BAD_LEN, 3 BAD_HDR, 4 RX_ERR.
- `rsp_type  out  8`: response byte 3.
- `rsp_length  out  8`: response byte 0.
- `rsp_data  out  64`: payload bytes 4..11, byte 4 in [63:56].

## Operation
- Packet format:
  - byte0 is the total length L, header included.
  - bytes 1 and 2 are 0x00.
  - byte3 is the type.
  - Payload is bytes 4..L-1.
- Requests are always L=8: 0x08, 0x00, 0x00, cmd_type, then 0x00 x4.
- States: IDLE, SEND, WAIT_LEN, READ.
- IDLE:
  - On `cmd_valid`, latch `cmd_type`, clear the byte index and `rsp_data`, and go to SEND.
  - `received` is ignored in IDLE.
- SEND:
  - Pulse `transmit` with the next byte whenever `is_transmitting`=0 and no pulse was issued the previous cycle.
  - After the 8th pulse, go to WAIT_LEN and reset the timer.
  - Bytes received during SEND are dropped.
- WAIT_LEN:
  - On `received`, handle the length byte:
    - 0x00: ignore it as a line filler, stay, reset the timer.
    - Below 8 or above `MAX_LEN`: finish with BAD_LEN, `rsp_length` = that byte.
    - Otherwise: latch L, set index=1, go to READ.
- READ:
  - Each `received` stores the byte at the current index, then increments the index:
    - Index 1 or 2 nonzero sets a sticky header-error flag.
    - Index 3 goes to `rsp_type`.
    - Indices 4..11 shift into `rsp_data` from the MSB end, left-aligned: byte 4 ends in [63:56].
    - Indices 12 and above are discarded.
  - When the stored index equals L-1, finish with OK, or with BAD_HDR if the flag is set.
  - A short payload (L < 12) leaves the unused low `rsp_data` bytes 0.
- Timer:
  - Counts in WAIT_LEN and READ; reset by each `received`.
  - Reaching `TIMEOUT_CYCLES`-1 finishes with TIMEOUT.
- `recv_error` in WAIT_LEN or READ finishes with RX_ERR immediately.
- When `received` and timeout occur in the same cycle, the byte wins and the timer resets.
- When `received` and `recv_error` occur in the same cycle, RX_ERR wins.
- Finish means: pulse `rsp_valid`, hold the `rsp_*` fields until the next accepted command, and return to IDLE.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1, `transmit`=0, `tx_byte`=0.
  - `rsp_valid`=0, `rsp_status`=0, `rsp_type`=0, `rsp_length`=0, `rsp_data`=0.
  - Timer 0, index 0.
- `cmd_valid` accepted at edge N: `cmd_ready`=0 from N+1, and the first `transmit` pulse no earlier than N+1.
- Minimum gap between `transmit` pulses is 2 cycles. This relies on the UART raising `is_transmitting` within one cycle of `transmit`.
- `rsp_valid` is asserted the cycle after the terminating `received`, `recv_error` or timer expiry. The fields are valid in that same cycle.
- `cmd_valid` while `cmd_ready`=0 is ignored, not queued.
- Asynchronous reset mid-packet:
  - Aborts at once: `transmit` drops, and no `rsp_valid` is emitted.
  - Remaining response bytes arriving after reset are ignored in IDLE.
- The index is 8 bits. L ≤ `MAX_LEN` ≤ 255, so there is no wrap.
- The timer is `$clog2(TIMEOUT_CYCLES)` bits and saturates at expiry.

## Structure
- Shared package `uart_comm_pkg`:
  - MSG_INFO=0, MSG_INVALID=1, MSG_MIN_LEN=8, REQ_LEN=8.
  - Status codes RSP_OK through RSP_RX_ERR.
  - The state enumeration.
- The UART receiver/transmitter module is not instantiated here; the top level wires it up.
- One sub-module, `uart_comm_timer`:
  - Loadable down-counter with clear on byte, enable, and one-cycle expire output.
  - Parameterised by `TIMEOUT_CYCLES`.

## Test plan
- `cmd_type`=0x00 with a responder model returning 0x10,0,0,0x00,DE,AD,BE,EF,13,37,0D,13,0,0,0,0 → transmit sequence 08 00 00 00 00 00 00 00; response fields:
  - `rsp_status`=0, `rsp_type`=0x00, `rsp_length`=0x10, `rsp_data`=0xDEADBEEF13370D13.
- Response 0x08,0,0,0x01,0,0,0,0 → status 0, `rsp_type`=0x01, `rsp_data`=0.
- Leading 0x00 filler, then length 0x05 → status BAD_LEN, `rsp_length`=0x05, one `rsp_valid`.
- Response header byte1=0x7F, L=8 → status BAD_HDR after the 8th byte; with `TIMEOUT_CYCLES`=100 and no response bytes → TIMEOUT exactly 100 cycles after entering WAIT_LEN.
- `rst_n` pulsed low after the 4th request byte → no further `transmit`, `cmd_ready`=1, no `rsp_valid`.
- `recv_error` coincident with `received` at index 5 → status RX_ERR; `cmd_valid` during SEND → ignored, exactly 8 bytes sent.
